if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage. It owns the fetch PC, issues single-outstanding requests on the instruction bus, and discards stale responses after a redirect. It presents one instruction per cycle to the IF/ID pipeline register via the bubble/pc/pc4/inst bundle, and holds a fetched instruction locally while the pipeline is stalled.

## Interface
- `RESET_ADDR`, default `32'h0000_0000`: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  IF/ID not accepting this cycle; same signal that drives IF/ID `stall`.
- `redirect`  in  1  branch/jump/trap redirect. Same cycle as IF/ID `squash`.
- `redirect_pc`  in  32  new fetch address, valid with `redirect`.
- `ibus_req`  out  1  request valid.
- `ibus_addr`  out  32  request address, word-aligned.
- `ibus_gnt`  in  1  request accepted this cycle; meaningful only when `ibus_req`=1.
- `ibus_rvalid`  in  1  response valid; arrives ≥1 cycle after the grant.
- `ibus_rdata`  in  32  response instruction.
- `bubble_o`  out  1  1 = no valid instruction this cycle.
- `pc_o`  out  32  PC of the presented instruction.
- `pc4_o`  out  32  `pc_o`+4, modulo 2^32.
- `inst_o`  out  32  presented instruction; 0 when `bubble_o`=1.

## Operation
- Registers:
  - `pc_q`: next request address.
  - `state_q`
  - `out_pc_q`: PC of the in-flight or held instruction.
  - `hold_inst_q`
- States:
  - FETCH: nothing outstanding.
  - WAIT: one request outstanding, result wanted.
  - HOLD: instruction captured, waiting for `!stall`.
  - DISCARD: one request outstanding, result stale.
- FETCH:
  - `ibus_req`=1, `ibus_addr`=`pc_q`, `bubble_o`=1.
  - `gnt` → WAIT, `out_pc_q`←`pc_q`, `pc_q`←`pc_q`+4.
- WAIT:
  - No `rvalid`: `bubble_o`=1, stay in WAIT.
  - `rvalid`: `bubble_o`=0, `pc_o`=`out_pc_q`, `inst_o`=`ibus_rdata` (combinational pass-through).
  - `rvalid` with `stall`: `hold_inst_q`←`rdata`, go to HOLD.
  - `rvalid` without `stall`: the next request issues in the same cycle, as in FETCH. `gnt` → WAIT with PC update, else → FETCH.
- HOLD:
  - `bubble_o`=0, `inst_o`=`hold_inst_q`, `pc_o`=`out_pc_q`.
  - `!stall`: request issues in the same cycle. `gnt` → WAIT, else → FETCH.
  - `stall`: stay in HOLD, `ibus_req`=0.
- DISCARD:
  - `ibus_req`=0, `bubble_o`=1.
  - `rvalid` → FETCH; the data is dropped.
- Redirect has highest priority in every state:
  - `ibus_req`=0, `bubble_o`=1, `pc_q`←`redirect_pc`.
  - Next state: WAIT without `rvalid` → DISCARD; DISCARD with `rvalid` → FETCH; DISCARD without `rvalid` → stay in DISCARD; FETCH or HOLD → FETCH.
- `pc_q` wraps modulo 2^32. `redirect_pc[1:0]` is ignored and forced to 0.
- Bus permits request withdrawal or address change before grant; the fetch stage relies on this on redirect.

## Timing
- Reset (async assert, sync-safe deassert):
  - state FETCH, `pc_q`=`RESET_ADDR`, `out_pc_q`=`RESET_ADDR`, `hold_inst_q`=0.
  - Outputs during reset: `bubble_o`=1, `pc_o`=`RESET_ADDR`, `pc4_o`=`RESET_ADDR`+4, `inst_o`=0, `ibus_req`=0.
  - Reset mid-transaction abandons any outstanding response. The bus is reset by the same `rst`.
- First `ibus_req` comes in the first cycle after reset deasserts.
- Zero-wait bus (`gnt` immediate, `rvalid` next cycle) sustains one instruction per cycle. Latency from grant to `bubble_o`=0 equals bus latency, with no added cycle.
- `rvalid`+`stall`+`redirect` in the same cycle: redirect wins, nothing is captured, next state FETCH.
- Outputs are combinational from state and bus inputs. IF/ID registers them.

## Structure
- `rv32` package: `word` type (already present); add `fetch_state_t` enum (FETCH/WAIT/HOLD/DISCARD).
- `RESET_ADDR` stays a module parameter.
- Optional sub-module `fetch_hold`: one-entry capture register, load/clear, valid plus data.

## Test plan
- Reset with `RESET_ADDR`=`32'h100`, zero-wait bus: `ibus_addr` sequence 0x100, 0x104, 0x108. `bubble_o`=0 every cycle from the first response, with `pc_o` 0x100, 0x104.
- `stall` held 3 cycles as `rvalid` delivers 0x104/`32'h00500093`: HOLD presents the same pc/inst for 3 cycles with `ibus_req`=0. On release, `ibus_addr`=0x108 in that cycle.
- Redirect to 0x200 while WAIT for 0x108, `rvalid` 2 cycles later: state DISCARD, the response is dropped (`bubble_o`=1). Next `ibus_addr`=0x200.
- `rvalid`, `stall` and `redirect` (to 0x300) in the same cycle: `bubble_o`=1, no HOLD. Next request address 0x300.
- `gnt` withheld 4 cycles at address 0x10C: `ibus_req`/`ibus_addr` stable and `bubble_o`=1 throughout. `pc_q` advances only on grant.
- `pc_q`=`32'hFFFF_FFFC` fetched: `pc4_o`=0 and next `ibus_addr`=0. Async `rst` mid-WAIT gives immediate reset outputs.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 types for the front end: machine word, fetch FSM states and
// small address helpers used by the fetch stage.
package rv32;

   typedef logic [31:0] word;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;

   localparam word INST_BYTES      = 32'd4;
   localparam word INST_ALIGN_MASK = 32'hFFFF_FFFC;

   // Instruction addresses are always word aligned; low bits are dropped.
   function automatic word align_word(input word addr);
      return addr & INST_ALIGN_MASK;
   endfunction

   // Sequential successor, wrapping modulo 2^32.
   function automatic word next_word(input word addr);
      return addr + INST_BYTES;
   endfunction

endpackage

// File: rtl/fetch_hold.sv
// One-entry capture register: keeps an instruction that arrived while the
// pipeline was stalled, with a valid flag that is loaded and cleared.
module fetch_hold
   import rv32::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   input  word  data_i,
   output logic valid_o,
   output word  data_o
);

   logic valid_q, valid_d;
   word  data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (clear) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one bus request in
// flight, drops stale responses after a redirect and holds data over stalls.
module if_fetch
   import rv32::*;
#(
   parameter word RESET_ADDR = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_gnt,
   input  logic        ibus_rvalid,
   input  logic [31:0] ibus_rdata,
   output logic        bubble_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic [31:0] inst_o
);

   fetch_state_t state_q, state_d;
   word          pc_q, pc_d;
   word          out_pc_q, out_pc_d;

   logic hold_load, hold_clear, hold_valid;
   word  hold_inst_q;

   logic issue;
   logic req_c;
   logic bubble_c;
   word  inst_c;

   fetch_hold u_hold (
      .clk     (clk),
      .rst     (rst),
      .load    (hold_load),
      .clear   (hold_clear),
      .data_i  (ibus_rdata),
      .valid_o (hold_valid),
      .data_o  (hold_inst_q)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      out_pc_d   = out_pc_q;
      hold_load  = 1'b0;
      hold_clear = 1'b0;
      issue      = 1'b0;
      req_c      = 1'b0;
      bubble_c   = 1'b1;
      inst_c     = '0;

      case (state_q)
         FETCH: issue = 1'b1;
         WAIT: begin
            if (ibus_rvalid) begin
               bubble_c = 1'b0;
               inst_c   = ibus_rdata;
               if (stall) begin
                  hold_load = 1'b1;
                  state_d   = HOLD;
               end else begin
                  issue = 1'b1;
               end
            end
         end
         HOLD: begin
            bubble_c = ~hold_valid;
            inst_c   = hold_valid ? hold_inst_q : '0;
            if (!stall) begin
               issue      = 1'b1;
               hold_clear = 1'b1;
            end
         end
         DISCARD: begin
            if (ibus_rvalid) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase

      // A request issued this cycle either lands (grant) or is retried from FETCH.
      if (issue) begin
         req_c = 1'b1;
         if (ibus_gnt) begin
            state_d  = WAIT;
            out_pc_d = pc_q;
            pc_d     = next_word(pc_q);
         end else begin
            state_d = FETCH;
         end
      end

      if (redirect) begin
         req_c      = 1'b0;
         bubble_c   = 1'b1;
         inst_c     = '0;
         hold_load  = 1'b0;
         hold_clear = 1'b1;
         out_pc_d   = out_pc_q;
         pc_d       = align_word(redirect_pc);
         case (state_q)
            WAIT:    state_d = ibus_rvalid ? FETCH : DISCARD;
            DISCARD: state_d = ibus_rvalid ? FETCH : DISCARD;
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_ADDR;
         out_pc_q <= RESET_ADDR;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         out_pc_q <= out_pc_d;
      end
   end

   // The bus shares rst, so no request may be presented while it is asserted.
   assign ibus_req  = req_c & ~rst;
   assign ibus_addr = pc_q;
   assign bubble_o  = bubble_c | rst;
   assign pc_o      = out_pc_q;
   assign pc4_o     = next_word(out_pc_q);
   assign inst_o    = rst ? '0 : inst_c;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_if_fetch;

   localparam logic [31:0] RST_ADDR = 32'h0000_0100;

   localparam int K_NONE  = 0;
   localparam int K_WANT  = 1;
   localparam int K_STALE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_gnt;
   logic        ibus_rvalid;
   logic [31:0] ibus_rdata;
   logic        bubble_o;
   logic [31:0] pc_o;
   logic [31:0] pc4_o;
   logic [31:0] inst_o;

   if_fetch #(.RESET_ADDR(RST_ADDR)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ibus_req    (ibus_req),
      .ibus_addr   (ibus_addr),
      .ibus_gnt    (ibus_gnt),
      .ibus_rvalid (ibus_rvalid),
      .ibus_rdata  (ibus_rdata),
      .bubble_o    (bubble_o),
      .pc_o        (pc_o),
      .pc4_o       (pc4_o),
      .inst_o      (inst_o)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Bus model: single outstanding, response lat cycles after grant.
   bit          bus_pend;
   int          bus_cnt;
   logic [31:0] bus_addr;
   int          cur_lat;
   logic        c_req;
   logic [31:0] c_addr;

   // Reference model: fetch pointer, what is in flight, what is being held.
   logic [31:0] m_fetch;
   logic [31:0] m_out_pc;
   logic [31:0] m_held_pc;
   int          m_kind;
   bit          m_held;
   bit          s_pres;
   bit          s_req;
   logic [31:0] s_ppc;

   typedef struct {
      bit          s;
      bit          r;
      logic [31:0] rpc;
      bit          g;
      int          lat;
      bit          eb;
      bit          er;
      logic [31:0] ea;
      logic [31:0] epc;
   } vec_t;

   vec_t tbl[20];

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0000_0104) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic vec_t v(input bit s, input bit r, input logic [31:0] rpc,
                              input bit g, input int lat, input bit eb, input bit er,
                              input logic [31:0] ea, input logic [31:0] epc);
      vec_t t;
      t.s = s; t.r = r; t.rpc = rpc; t.g = g; t.lat = lat;
      t.eb = eb; t.er = er; t.ea = ea; t.epc = epc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_init();
      m_fetch  = RST_ADDR;
      m_out_pc = RST_ADDR;
      m_held_pc = RST_ADDR;
      m_kind   = K_NONE;
      m_held   = 1'b0;
      bus_pend = 1'b0;
      bus_cnt  = 0;
      bus_addr = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_bubble"}, bubble_o, 1);
      chk({tag, "_req"}, ibus_req, 0);
      chk({tag, "_pc"}, pc_o, RST_ADDR);
      chk({tag, "_pc4"}, pc4_o, RST_ADDR + 32'd4);
      chk({tag, "_inst"}, inst_o, 0);
   endtask

   // Called at posedge+1: present bus response, then compare at the negedge.
   task automatic sample();
      ibus_rvalid = bus_pend && (bus_cnt == 0);
      ibus_rdata  = ibus_rvalid ? mem(bus_addr) : $urandom;
      @(negedge clk);
      s_pres = !redirect && (m_held || (m_kind == K_WANT && ibus_rvalid));
      s_ppc  = m_held ? m_held_pc : m_out_pc;
      if (redirect)    s_req = 1'b0;
      else if (m_held) s_req = !stall;
      else             s_req = (m_kind == K_NONE) ||
                               (m_kind == K_WANT && ibus_rvalid && !stall);
      chk("m_bubble", bubble_o, !s_pres);
      chk("m_req", ibus_req, s_req);
      if (s_req && ibus_req) chk("m_addr", ibus_addr, m_fetch);
      if (s_pres) begin
         chk("m_pc", pc_o, s_ppc);
         chk("m_pc4", pc4_o, s_ppc + 32'd4);
         chk("m_inst", inst_o, mem(s_ppc));
      end else begin
         chk("m_inst0", inst_o, 0);
      end
      c_req  = ibus_req;
      c_addr = ibus_addr;
   endtask

   // Clock edge: advance model and bus, then return at posedge+1.
   task automatic advance();
      @(posedge clk);
      if (redirect) begin
         m_kind  = (m_kind != K_NONE && !ibus_rvalid) ? K_STALE : K_NONE;
         m_held  = 1'b0;
         m_fetch = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (ibus_rvalid) m_kind = K_NONE;
         if (s_pres && stall) begin
            m_held    = 1'b1;
            m_held_pc = s_ppc;
         end else begin
            m_held = 1'b0;
         end
         if (s_req && ibus_gnt) begin
            m_kind   = K_WANT;
            m_out_pc = m_fetch;
            m_fetch  = m_fetch + 32'd4;
         end
      end
      if (ibus_rvalid)   bus_pend = 1'b0;
      else if (bus_pend) bus_cnt--;
      if (c_req && ibus_gnt) begin
         bus_pend = 1'b1;
         bus_addr = c_addr;
         bus_cnt  = cur_lat - 1;
      end
      #1;
   endtask

   task automatic set_in(input bit s, input bit r, input logic [31:0] rpc,
                         input bit g, input int lat);
      stall = s; redirect = r; redirect_pc = rpc; ibus_gnt = g; cur_lat = lat;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      set_in(0, 0, 0, 0, 1);
      ibus_rvalid = 1'b0;
      ibus_rdata  = '0;
      #1;
      chk_reset_outputs("rst");
      @(posedge clk);
      @(posedge clk);
      model_init();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      model_init();
      apply_reset();

      // Directed table: zero-wait stream, stall/hold, redirect/discard,
      // redirect+rvalid+stall, withheld grant.
      tbl[0]  = v(0, 0, 0,            1, 1, 1, 1, 32'h100, 0);
      tbl[1]  = v(0, 0, 0,            1, 1, 0, 1, 32'h104, 32'h100);
      tbl[2]  = v(1, 0, 0,            1, 1, 0, 0, 0,       32'h104);
      tbl[3]  = v(1, 0, 0,            1, 1, 0, 0, 0,       32'h104);
      tbl[4]  = v(1, 0, 0,            1, 1, 0, 0, 0,       32'h104);
      tbl[5]  = v(0, 0, 0,            1, 3, 0, 1, 32'h108, 32'h104);
      tbl[6]  = v(0, 1, 32'h200,      1, 1, 1, 0, 0,       0);
      tbl[7]  = v(0, 0, 0,            1, 1, 1, 0, 0,       0);
      tbl[8]  = v(0, 0, 0,            1, 1, 1, 0, 0,       0);
      tbl[9]  = v(0, 0, 0,            1, 1, 1, 1, 32'h200, 0);
      tbl[10] = v(1, 1, 32'h300,      1, 1, 1, 0, 0,       0);
      tbl[11] = v(0, 0, 0,            1, 1, 1, 1, 32'h300, 0);
      tbl[12] = v(0, 1, 32'h10C,      1, 1, 1, 0, 0,       0);
      tbl[13] = v(0, 0, 0,            0, 1, 1, 1, 32'h10C, 0);
      tbl[14] = v(0, 0, 0,            0, 1, 1, 1, 32'h10C, 0);
      tbl[15] = v(0, 0, 0,            0, 1, 1, 1, 32'h10C, 0);
      tbl[16] = v(0, 0, 0,            0, 1, 1, 1, 32'h10C, 0);
      tbl[17] = v(0, 0, 0,            1, 1, 1, 1, 32'h10C, 0);
      tbl[18] = v(0, 0, 0,            1, 1, 0, 1, 32'h110, 32'h10C);
      tbl[19] = v(0, 0, 0,            1, 1, 0, 1, 32'h114, 32'h110);

      for (int i = 0; i < 20; i++) begin
         set_in(tbl[i].s, tbl[i].r, tbl[i].rpc, tbl[i].g, tbl[i].lat);
         sample();
         chk($sformatf("t%0d_bubble", i), bubble_o, tbl[i].eb);
         chk($sformatf("t%0d_req", i), ibus_req, tbl[i].er);
         if (tbl[i].er) chk($sformatf("t%0d_addr", i), ibus_addr, tbl[i].ea);
         if (!tbl[i].eb) begin
            chk($sformatf("t%0d_pc", i), pc_o, tbl[i].epc);
            chk($sformatf("t%0d_inst", i), inst_o, mem(tbl[i].epc));
         end
         $display("vec %0d: bubble=%0b req=%0b addr=%h pc=%h inst=%h",
                  i, bubble_o, ibus_req, ibus_addr, pc_o, inst_o);
         advance();
      end

      // Wrap: fetch at 0xFFFF_FFFC, low redirect bits ignored.
      set_in(0, 1, 32'hFFFF_FFFE, 1, 1);
      sample();
      chk("wrap_redir_bubble", bubble_o, 1);
      chk("wrap_redir_req", ibus_req, 0);
      advance();
      set_in(0, 0, 0, 1, 1);
      sample();
      chk("wrap_req_addr", ibus_addr, 32'hFFFF_FFFC);
      advance();
      set_in(0, 0, 0, 1, 3);
      sample();
      chk("wrap_bubble", bubble_o, 0);
      chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc4_o, 32'h0);
      chk("wrap_next_addr", ibus_addr, 32'h0);
      $display("wrap: pc=%h pc4=%h next_addr=%h", pc_o, pc4_o, ibus_addr);
      advance();

      // Async reset while WAIT for address 0 is outstanding.
      set_in(0, 0, 0, 1, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      $display("async reset: bubble=%0b req=%0b pc=%h", bubble_o, ibus_req, pc_o);
      @(posedge clk);
      model_init();
      #1;
      rst = 1'b0;
      set_in(0, 0, 0, 1, 1);
      sample();
      chk("post_rst_addr", ibus_addr, RST_ADDR);
      advance();

      // Randomized run against the reference model.
      for (int i = 0; i < 3000; i++) begin
         set_in(($urandom % 4) == 0, ($urandom % 16) == 0, $urandom,
                ($urandom % 3) != 0, 1 + int'($urandom % 3));
         sample();
         if (i % 500 == 0)
            $display("rand %0d: bubble=%0b req=%0b addr=%h pc=%h", i, bubble_o, ibus_req, ibus_addr, pc_o);
         advance();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
